// File: rtl/pcpi_fabric_ctrl_if.sv
// PCPI handshake plus fabric configuration/execution pins for pcpi_fabric_ctrl.
// slave is the controller's view; master is the CPU/fabric side.
interface pcpi_fabric_ctrl_if #(
    parameter int CFG_HEIGHT = 64
);
    logic                  pcpi_valid;
    logic [31:0]           pcpi_insn;
    logic [31:0]           pcpi_rs1;
    logic [31:0]           pcpi_rs2;
    logic                  pcpi_wr;
    logic [31:0]           pcpi_rd;
    logic                  pcpi_wait;
    logic                  pcpi_ready;
    logic                  fab_shift;
    logic [CFG_HEIGHT-1:0] fab_cdata;
    logic                  fab_valid;
    logic [31:0]           fab_rs1;
    logic [31:0]           fab_rs2;
    logic [31:0]           fab_rd;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, fab_rd,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
               fab_shift, fab_cdata, fab_valid, fab_rs1, fab_rs2
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, fab_rd,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
               fab_shift, fab_cdata, fab_valid, fab_rs1, fab_rs2
    );
endinterface

// File: rtl/pcpi_fabric_ctrl.sv
// PCPI coprocessor front end: packs CPU words into fabric configuration columns
// and runs fixed-window fabric evaluations, returning the result to the CPU.
module pcpi_fabric_ctrl #(
    parameter int         CFG_HEIGHT  = 64,
    parameter int         NUM_COLS    = 16,
    parameter int         EVAL_CYCLES = 2,
    parameter logic [6:0] OPCODE      = 7'b0001011
) (
    input logic clk,
    input logic rst,
    pcpi_fabric_ctrl_if.slave bus
);
    localparam int W   = (CFG_HEIGHT + 31) / 32;
    localparam int WIW = (W > 1) ? $clog2(W) : 1;
    localparam int ECW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [15:0]    COLS_MAX = 16'(NUM_COLS);
    localparam logic [WIW-1:0] LAST_WORD = WIW'(W - 1);
    localparam logic [ECW-1:0] EVAL_LAST = ECW'(EVAL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, BUSY, SHIFT, EVAL, DONE, DRAIN} state_t;
    typedef enum logic [1:0] {OP_PUSH, OP_CLEAR, OP_EXEC, OP_STATUS} op_t;

    state_t                state;
    op_t                   op;
    logic [31:0]           rs1_q;
    logic [31:0]           rs2_q;
    logic [WIW-1:0]        word_idx;
    logic [15:0]           col_count;
    logic                  configured;
    logic [CFG_HEIGHT-1:0] col_buf;
    logic [ECW-1:0]        eval_cnt;

    logic                  match;
    logic [W*32-1:0]       buf_wide;
    logic [W*32-1:0]       buf_merged;
    logic [CFG_HEIGHT-1:0] buf_next;
    logic [15:0]           cols_inc;

    // funct7 in {0..3} means the upper five funct7 bits are zero.
    assign match = bus.pcpi_valid && (bus.pcpi_insn[6:0] == OPCODE)
                   && (bus.pcpi_insn[31:27] == 5'd0);

    assign cols_inc = (col_count < COLS_MAX) ? col_count + 16'd1 : col_count;

    // Word slot merge; bits beyond CFG_HEIGHT fall off in the truncation.
    always_comb begin
        buf_wide = '0;
        buf_wide[CFG_HEIGHT-1:0] = col_buf;
        buf_merged = buf_wide;
        for (int i = 0; i < W; i++) begin
            if (WIW'(i) == word_idx) buf_merged[32*i +: 32] = rs1_q;
        end
        buf_next = buf_merged[CFG_HEIGHT-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            op             <= OP_PUSH;
            rs1_q          <= '0;
            rs2_q          <= '0;
            word_idx       <= '0;
            col_count      <= '0;
            configured     <= 1'b0;
            col_buf        <= '0;
            eval_cnt       <= '0;
            bus.pcpi_wr    <= 1'b0;
            bus.pcpi_rd    <= '0;
            bus.pcpi_wait  <= 1'b0;
            bus.pcpi_ready <= 1'b0;
            bus.fab_shift  <= 1'b0;
            bus.fab_cdata  <= '0;
            bus.fab_valid  <= 1'b0;
            bus.fab_rs1    <= '0;
            bus.fab_rs2    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        op            <= op_t'(bus.pcpi_insn[26:25]);
                        rs1_q         <= bus.pcpi_rs1;
                        rs2_q         <= bus.pcpi_rs2;
                        bus.pcpi_wait <= 1'b1;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    case (op)
                        OP_PUSH: begin
                            if (configured) begin
                                bus.pcpi_rd    <= 32'd1;
                                bus.pcpi_wr    <= 1'b0;
                                bus.pcpi_ready <= 1'b1;
                                bus.pcpi_wait  <= 1'b0;
                                state          <= DONE;
                            end else if (word_idx == LAST_WORD) begin
                                col_buf       <= buf_next;
                                word_idx      <= '0;
                                bus.fab_shift <= 1'b1;
                                bus.fab_cdata <= buf_next;
                                state         <= SHIFT;
                            end else begin
                                col_buf        <= buf_next;
                                word_idx       <= word_idx + 1'b1;
                                bus.pcpi_rd    <= '0;
                                bus.pcpi_wr    <= 1'b0;
                                bus.pcpi_ready <= 1'b1;
                                bus.pcpi_wait  <= 1'b0;
                                state          <= DONE;
                            end
                        end
                        OP_CLEAR: begin
                            word_idx       <= '0;
                            col_count      <= '0;
                            configured     <= 1'b0;
                            col_buf        <= '0;
                            bus.pcpi_rd    <= '0;
                            bus.pcpi_wr    <= 1'b0;
                            bus.pcpi_ready <= 1'b1;
                            bus.pcpi_wait  <= 1'b0;
                            state          <= DONE;
                        end
                        OP_EXEC: begin
                            if (!configured) begin
                                bus.pcpi_rd    <= 32'hFFFF_FFFF;
                                bus.pcpi_wr    <= 1'b1;
                                bus.pcpi_ready <= 1'b1;
                                bus.pcpi_wait  <= 1'b0;
                                state          <= DONE;
                            end else begin
                                bus.fab_rs1   <= rs1_q;
                                bus.fab_rs2   <= rs2_q;
                                bus.fab_valid <= 1'b1;
                                eval_cnt      <= EVAL_LAST;
                                state         <= EVAL;
                            end
                        end
                        OP_STATUS: begin
                            bus.pcpi_rd    <= {configured, 15'd0, col_count};
                            bus.pcpi_wr    <= 1'b1;
                            bus.pcpi_ready <= 1'b1;
                            bus.pcpi_wait  <= 1'b0;
                            state          <= DONE;
                        end
                        default: state <= IDLE;
                    endcase
                end
                SHIFT: begin
                    bus.fab_shift  <= 1'b0;
                    col_count      <= cols_inc;
                    configured     <= (cols_inc == COLS_MAX);
                    bus.pcpi_rd    <= '0;
                    bus.pcpi_wr    <= 1'b0;
                    bus.pcpi_ready <= 1'b1;
                    bus.pcpi_wait  <= 1'b0;
                    state          <= DONE;
                end
                EVAL: begin
                    // Result is taken in the final cycle of the window.
                    if (eval_cnt == '0) begin
                        bus.fab_valid  <= 1'b0;
                        bus.pcpi_rd    <= bus.fab_rd;
                        bus.pcpi_wr    <= 1'b1;
                        bus.pcpi_ready <= 1'b1;
                        bus.pcpi_wait  <= 1'b0;
                        state          <= DONE;
                    end else begin
                        eval_cnt <= eval_cnt - 1'b1;
                    end
                end
                DONE: begin
                    bus.pcpi_ready <= 1'b0;
                    bus.pcpi_wr    <= 1'b0;
                    bus.pcpi_rd    <= '0;
                    state          <= DRAIN;
                end
                DRAIN: begin
                    // Wait for the CPU to retire the instruction before re-arming.
                    if (!bus.pcpi_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_fabric_ctrl.sv
// Bench for pcpi_fabric_ctrl: directed vector table, hand-written corner sequences,
// and random instruction streams checked against an abstract configuration model.
module tb_pcpi_fabric_ctrl;
    localparam int         CH = 64;
    localparam int         NC = 2;
    localparam int         EC = 2;
    localparam int         W  = (CH + 31) / 32;
    localparam logic [6:0] OPC = 7'b0001011;

    typedef struct {
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          lat;
        logic        wr;
        logic [31:0] rd;
        int          shifts;
        logic [63:0] cdata;
        int          vcyc;
    } vec_t;

    logic clk;
    logic rst;
    pcpi_fabric_ctrl_if #(.CFG_HEIGHT(CH)) bus ();

    pcpi_fabric_ctrl #(
        .CFG_HEIGHT(CH), .NUM_COLS(NC), .EVAL_CYCLES(EC), .OPCODE(OPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fabric stand-in: mode 1 folds in how long fab_valid has been held, so a
    // result sampled in the wrong cycle of the window shows up.
    logic        fab_mode;
    logic [31:0] vrun;
    always @(posedge clk) vrun <= bus.fab_valid ? vrun + 32'd1 : 32'd0;
    assign bus.fab_rd = fab_mode ? (bus.fab_rs1 + bus.fab_rs2 + vrun) : bus.fab_rs1;

    int          shift_cnt;
    int          valid_cnt;
    int          ready_cnt;
    logic [63:0] last_cdata;
    initial begin
        shift_cnt = 0; valid_cnt = 0; ready_cnt = 0; last_cdata = '0;
    end
    always @(negedge clk) begin
        if (bus.fab_shift) begin
            shift_cnt++;
            last_cdata = bus.fab_cdata;
        end
        if (bus.fab_valid) valid_cnt++;
        if (bus.pcpi_ready) ready_cnt++;
    end

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending word slot, column count, configured flag.
    int          m_pend;
    int          m_cols;
    bit          m_cfg;
    logic [63:0] m_buf;

    task automatic model_reset();
        m_pend = 0; m_cols = 0; m_cfg = 1'b0; m_buf = '0;
    endtask

    task automatic model(input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                         output vec_t v);
        v = '{f7: f7, rs1: rs1, rs2: rs2, lat: 2, wr: 1'b0, rd: 32'd0,
              shifts: 0, cdata: 64'd0, vcyc: 0};
        case (f7)
            7'd0: begin
                if (m_cfg) v.rd = 32'd1;
                else begin
                    m_buf[32*m_pend +: 32] = rs1;
                    if (m_pend == W - 1) begin
                        m_pend = 0;
                        v.shifts = 1;
                        v.cdata = m_buf;
                        v.lat = 3;
                        if (m_cols < NC) m_cols++;
                        m_cfg = (m_cols == NC);
                    end else m_pend++;
                end
            end
            7'd1: model_reset();
            7'd2: begin
                v.wr = 1'b1;
                if (!m_cfg) v.rd = 32'hFFFF_FFFF;
                else begin
                    v.lat = 2 + EC;
                    v.vcyc = EC;
                    v.rd = fab_mode ? rs1 + rs2 + 32'(EC - 1) : rs1;
                end
            end
            default: begin
                v.wr = 1'b1;
                v.rd = {m_cfg, 15'd0, 16'(m_cols)};
            end
        endcase
    endtask

    function automatic vec_t mkv(input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input int lat, input logic wr, input logic [31:0] rd,
                                 input int sh, input logic [63:0] cd, input int vc);
        vec_t v;
        v = '{f7: f7, rs1: rs1, rs2: rs2, lat: lat, wr: wr, rd: rd, shifts: sh, cdata: cd, vcyc: vc};
        return v;
    endfunction

    // Issue one instruction, hold pcpi_valid 'hold' cycles past ready, then check.
    task automatic apply(input vec_t v, input int hold, input string tag);
        int lat, sh0, v0, r0, wbad;
        logic wr;
        logic [31:0] rd;
        @(posedge clk); #1;
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = {v.f7, 18'($urandom), OPC};
        bus.pcpi_rs1   = v.rs1;
        bus.pcpi_rs2   = v.rs2;
        sh0 = shift_cnt; v0 = valid_cnt; r0 = ready_cnt;
        lat = -1; wbad = 0; wr = 1'b0; rd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.pcpi_wait !== ((c >= 1) && !bus.pcpi_ready)) wbad++;
            if (bus.pcpi_ready === 1'b1) begin
                lat = c; wr = bus.pcpi_wr; rd = bus.pcpi_rd;
                break;
            end
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        bus.pcpi_valid = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s.latency", tag), 64'(lat), 64'(v.lat));
        chk($sformatf("%s.wr", tag), 64'(wr), 64'(v.wr));
        chk($sformatf("%s.rd", tag), 64'(rd), 64'(v.rd));
        chk($sformatf("%s.wait", tag), 64'(wbad), 64'd0);
        chk($sformatf("%s.ready_pulses", tag), 64'(ready_cnt - r0), 64'd1);
        chk($sformatf("%s.shifts", tag), 64'(shift_cnt - sh0), 64'(v.shifts));
        chk($sformatf("%s.valid_cycles", tag), 64'(valid_cnt - v0), 64'(v.vcyc));
        if (v.shifts > 0) chk($sformatf("%s.cdata", tag), last_cdata, v.cdata);
        if (v.vcyc > 0) begin
            chk($sformatf("%s.fab_rs1", tag), 64'(bus.fab_rs1), 64'(v.rs1));
            chk($sformatf("%s.fab_rs2", tag), 64'(bus.fab_rs2), 64'(v.rs2));
        end
    endtask

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t mv;
        int   bad, r0;
        n_vec = 0; n_err = 0;
        fab_mode = 1'b0;
        model_reset();

        tbl[0]  = mkv(7'd2, 32'h1234_5678, 32'h0000_0001, 2, 1'b1, 32'hFFFF_FFFF, 0, 64'd0, 0);
        tbl[1]  = mkv(7'd3, 32'h0, 32'h0, 2, 1'b1, 32'h0000_0000, 0, 64'd0, 0);
        tbl[2]  = mkv(7'd0, 32'h0000_000F, 32'h0, 2, 1'b0, 32'h0, 0, 64'd0, 0);
        tbl[3]  = mkv(7'd0, 32'hCA7F_100F, 32'h0, 3, 1'b0, 32'h0, 1, 64'hCA7F100F_0000000F, 0);
        tbl[4]  = mkv(7'd3, 32'h0, 32'h0, 2, 1'b1, 32'h0000_0001, 0, 64'd0, 0);
        tbl[5]  = mkv(7'd0, 32'h1111_1111, 32'h0, 2, 1'b0, 32'h0, 0, 64'd0, 0);
        tbl[6]  = mkv(7'd0, 32'h2222_2222, 32'h0, 3, 1'b0, 32'h0, 1, 64'h22222222_11111111, 0);
        tbl[7]  = mkv(7'd3, 32'h0, 32'h0, 2, 1'b1, 32'h8000_0002, 0, 64'd0, 0);
        tbl[8]  = mkv(7'd0, 32'h3333_3333, 32'h0, 2, 1'b0, 32'h0000_0001, 0, 64'd0, 0);
        tbl[9]  = mkv(7'd3, 32'h0, 32'h0, 2, 1'b1, 32'h8000_0002, 0, 64'd0, 0);
        tbl[10] = mkv(7'd2, 32'hCA7F_100F, 32'h1234_5678, 4, 1'b1, 32'hCA7F_100F, 0, 64'd0, 2);
        tbl[11] = mkv(7'd1, 32'h0, 32'h0, 2, 1'b0, 32'h0, 0, 64'd0, 0);
        tbl[12] = mkv(7'd3, 32'h0, 32'h0, 2, 1'b1, 32'h0000_0000, 0, 64'd0, 0);

        rst = 1'b0;
        bus.pcpi_valid = 1'b0; bus.pcpi_insn = '0; bus.pcpi_rs1 = '0; bus.pcpi_rs2 = '0;
        repeat (2) @(negedge clk);
        chk("reset.pcpi", {bus.pcpi_wr, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_rd}, 64'd0);
        chk("reset.fab_ctl", {bus.fab_shift, bus.fab_valid}, 64'd0);
        chk("reset.fab_cdata", bus.fab_cdata, 64'd0);
        chk("reset.fab_ops", {bus.fab_rs1, bus.fab_rs2}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Directed sequence, rows 0..10 (row 10 leaves the fabric configured).
        for (int i = 0; i <= 10; i++) begin
            model(tbl[i].f7, tbl[i].rs1, tbl[i].rs2, mv);
            apply(tbl[i], 0, $sformatf("dir%0d", i));
        end

        // Reset asserted in the middle of an evaluation window.
        @(posedge clk); #1;
        bus.pcpi_valid = 1'b1; bus.pcpi_insn = {7'd2, 18'd0, OPC};
        bus.pcpi_rs1 = 32'hA5A5_A5A5; bus.pcpi_rs2 = 32'h1;
        r0 = ready_cnt;
        repeat (3) @(negedge clk);
        chk("midrst.valid_before", 64'(bus.fab_valid), 64'd1);
        chk("midrst.wait_before", 64'(bus.pcpi_wait), 64'd1);
        #1 rst = 1'b0; bus.pcpi_valid = 1'b0;
        #1;
        chk("midrst.after", {bus.fab_valid, bus.pcpi_wait, bus.pcpi_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst.no_ready", 64'(ready_cnt - r0), 64'd0);
        model_reset();
        model(tbl[12].f7, 32'h0, 32'h0, mv);
        apply(tbl[12], 0, "midrst.status");

        // Valid held past ready: one pulse only, then clear/status.
        model(tbl[2].f7, tbl[2].rs1, 32'h0, mv);
        apply(tbl[2], 5, "hold.push");
        model(tbl[11].f7, 32'h0, 32'h0, mv);
        apply(tbl[11], 5, "hold.clear");
        model(tbl[12].f7, 32'h0, 32'h0, mv);
        apply(tbl[12], 0, "hold.status");

        // Foreign opcode, then a matching opcode with out-of-range funct7.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus.pcpi_valid = 1'b1;
            bus.pcpi_insn  = (k == 0) ? {7'd2, 18'd0, 7'b0110011} : {7'd5, 18'd0, OPC};
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.pcpi_wait !== 1'b0 || bus.pcpi_ready !== 1'b0) bad++;
            end
            chk($sformatf("foreign%0d.unclaimed", k), 64'(bad), 64'd0);
            @(posedge clk); #1 bus.pcpi_valid = 1'b0;
        end

        // Random instruction stream against the model.
        fab_mode = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int          r;
            logic [6:0]  f7;
            logic [31:0] a, b;
            r  = $urandom_range(0, 99);
            f7 = (r < 50) ? 7'd0 : (r < 55) ? 7'd1 : (r < 80) ? 7'd2 : 7'd3;
            a  = $urandom;
            b  = $urandom;
            model(f7, a, b, mv);
            apply(mv, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pcpi_fabric_ctrl.md
Name: pcpi_fabric_ctrl

Overview:
- PCPI coprocessor front end that owns the reconfigurable fabric.
- Handles two jobs: bitstream download (32-bit CPU words packed into CFG_HEIGHT-bit columns, one fabric shift pulse per column) and fabric execution (operands presented for a fixed evaluation window, result returned).
- Sits between the PicoRV32 PCPI port and the fabric's shift/cdata/operand pins.
- Replaces testbench-side bitstream loading with CPU-driven custom instructions.

Parameters:
- CFG_HEIGHT, 64: column width in bits (≥1); words per column W = ceil(CFG_HEIGHT/32).
- NUM_COLS, 16: columns in a full bitstream (≥1).
- EVAL_CYCLES, 2: cycles fab_valid is held before fab_rd is sampled (≥1).
- OPCODE, 7'b0001011: custom-0 major opcode matched on pcpi_insn[6:0].

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-low reset.
- pcpi_valid, input, 1: instruction offered.
- pcpi_insn, input, 32: instruction word.
- pcpi_rs1, input, 32: source operand 1.
- pcpi_rs2, input, 32: source operand 2.
- pcpi_wr, output, 1: rd write enable, valid with pcpi_ready.
- pcpi_rd, output, 32: result, valid with pcpi_ready.
- pcpi_wait, output, 1: instruction claimed, busy.
- pcpi_ready, output, 1: one-cycle completion pulse.
- fab_shift, output, 1: one-cycle column shift strobe.
- fab_cdata, output, CFG_HEIGHT: column data, stable while fab_shift=1.
- fab_valid, output, 1: operands valid, evaluation window.
- fab_rs1, output, 32: fabric operand 1.
- fab_rs2, output, 32: fabric operand 2.
- fab_rd, input, 32: fabric result.

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; word_idx=0; col_count=0; configured=0; column buffer 0. Reset mid-operation aborts with no ready pulse.
- Match condition: pcpi_valid & insn[6:0]==OPCODE & funct7=insn[31:25] in {0,1,2,3}. Anything else is never claimed: wait and ready stay 0.
- Ops:
  - 0 CFG_PUSH: write rs1 to buffer bits [32*word_idx+31 : 32*word_idx]; bits at or above CFG_HEIGHT are dropped.
  - 1 CFG_CLEAR: word_idx=0, col_count=0, configured=0, buffer=0.
  - 2 EXEC: run the fabric.
  - 3 STATUS: rd = {configured, 15'b0, col_count zero-extended to 16 bits}.
- FSM: IDLE → BUSY → (SHIFT | EVAL) → DONE → DRAIN → IDLE.
  - IDLE (cycle T, match seen): latch funct7, rs1, rs2. Go BUSY. pcpi_wait=1 from T+1 until the DONE cycle, exclusive.
  - BUSY, CFG_PUSH:
    - Store the word.
    - If word_idx==W-1: word_idx=0 and go SHIFT. Otherwise word_idx++ and go DONE.
    - If configured=1: store nothing and go DONE; rd=1 (overflow flag).
  - BUSY, CFG_CLEAR / STATUS: go DONE.
  - BUSY, EXEC:
    - configured=0: go DONE with rd=32'hFFFF_FFFF.
    - Otherwise drive fab_rs1/fab_rs2 from the latches, fab_valid=1, and go EVAL.
  - SHIFT: fab_shift=1 for exactly one cycle, fab_cdata=buffer. col_count++. configured=1 when col_count reaches NUM_COLS. Go DONE.
  - EVAL: fab_valid stays 1 for exactly EVAL_CYCLES cycles. fab_rd is sampled in the last cycle; fab_valid drops the next cycle. Go DONE.
  - DONE: pcpi_ready=1 and pcpi_wait=0 for one cycle.
    - pcpi_wr=1 for EXEC and STATUS; 0 for CFG_PUSH and CFG_CLEAR.
    - pcpi_rd holds the result, otherwise 0.
  - DRAIN: stay until pcpi_valid=0, so the same instruction is never re-executed. Go IDLE.
- Latency, valid to ready:
  - CFG_PUSH without shift, CFG_CLEAR, STATUS: 2 cycles.
  - CFG_PUSH with shift: 3 cycles.
  - EXEC: 2+EVAL_CYCLES cycles.
- If pcpi_valid drops during BUSY/SHIFT/EVAL, the operation still completes and ready still pulses; the CPU ignores it.
- fab_cdata holds its last value between shifts. fab_rs1/fab_rs2 hold their values after EVAL.
- col_count saturates at NUM_COLS and never wraps.

Test Plan (CFG_HEIGHT=64, NUM_COLS=2, EVAL_CYCLES=2):
- Reset mid-run: assert rst low during EVAL → fab_valid, pcpi_wait, pcpi_ready fall immediately; STATUS after release returns 0.
- Column load: push 0x0000000F then 0xCA7F100F → one fab_shift pulse with fab_cdata=64'hCA7F100F_0000000F; ready 3 cycles after the second valid; STATUS rd=0x00000001.
- Full configure: push 4 words → exactly 2 shift pulses; STATUS rd=0x80000002; a 5th push returns with no shift pulse and col_count stays 2.
- Execute: configured, EXEC rs1=0xCA7F100F with fab_rd driven = rs1 → fab_valid high 2 cycles; pcpi_wr=1, pcpi_rd=0xCA7F100F; ready 4 cycles after valid.
- Unconfigured EXEC → rd=0xFFFFFFFF, wr=1, fab_valid never asserted. Foreign opcode (insn[6:0]=0110011) → pcpi_wait and pcpi_ready stay 0 for 20 cycles.
- Handshake: hold pcpi_valid high 5 cycles past ready → exactly one ready pulse; CFG_CLEAR then STATUS → rd=0, pcpi_wr=0 on CFG_CLEAR.
